// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg : shared RV32I core types and constants
// Rev 1.0   : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
    logic            valid;
  } if_id_t;

  // Bubble used on reset and flush; decode treats valid = 0 as a no-op.
  function automatic if_id_t if_id_bubble(input logic [31:0] nop);
    if_id_t b;
    b.instr     = nop;
    b.pc        = '0;
    b.pc_plus_4 = '0;
    b.valid     = 1'b0;
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_fetch_if.sv
// ---------------------------------------------------------------------------
// pipe_fetch_if : control, imem and IF/ID signals of the fetch stage
// Rev 1.0       : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface pipe_fetch_if;
  import riscv_pkg::*;

  logic            stall_f;
  logic            stall_d;
  logic            flush_d;
  logic            pc_src_e;
  logic [XLEN-1:0] pc_target_e;
  logic [31:0]     instr_f;
  logic [XLEN-1:0] pc_f;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus_4_d;
  logic            valid_d;
  logic            misalign_err;

  // slave = the fetch stage itself
  modport slave (
    input  stall_f, stall_d, flush_d, pc_src_e, pc_target_e, instr_f,
    output pc_f, instr_d, pc_d, pc_plus_4_d, valid_d, misalign_err
  );

  modport master (
    output stall_f, stall_d, flush_d, pc_src_e, pc_target_e, instr_f,
    input  pc_f, instr_d, pc_d, pc_plus_4_d, valid_d, misalign_err
  );

endinterface

`default_nettype wire

// File: rtl/pipe_fetch_pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg : XLEN-wide register with enable, load value and async low reset
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pc_reg #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  input  wire logic            en,
  input  wire logic [XLEN-1:0] load_val,
  output logic      [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (en) begin
      pc_d = load_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/pipe_fetch.sv
// ---------------------------------------------------------------------------
// pipe_fetch : fetch stage and IF/ID pipeline register of the RV32I core
// Rev 1.0    : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  wire logic    clk,
  input  wire logic    reset_n,
  pipe_fetch_if.slave  bus
);

  logic [XLEN-1:0] pc_cur;
  logic [XLEN-1:0] pc_plus_4_f;
  logic [XLEN-1:0] pc_next;
  logic            pc_en;

  if_id_t if_id_d;
  if_id_t if_id_q;
  logic   misalign_d;
  logic   misalign_q;

  assign pc_plus_4_f = pc_cur + XLEN'(4);

  // A redirect wins over stall_f; the target is force-aligned.
  always_comb begin
    pc_next = pc_plus_4_f;
    pc_en   = !bus.stall_f;
    if (bus.pc_src_e) begin
      pc_next = {bus.pc_target_e[XLEN-1:2], 2'b00};
      pc_en   = 1'b1;
    end
  end

  pc_reg #(
    .XLEN      (XLEN),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (pc_en),
    .load_val (pc_next),
    .pc       (pc_cur)
  );

  always_comb begin
    if_id_d = if_id_q;
    if (bus.flush_d) begin
      if_id_d = if_id_bubble(NOP_INSTR);
    end else if (!bus.stall_d) begin
      if_id_d.instr     = bus.instr_f;
      if_id_d.pc        = pc_cur;
      if_id_d.pc_plus_4 = pc_plus_4_f;
      if_id_d.valid     = 1'b1;
    end
  end

  always_comb begin
    misalign_d = misalign_q | (bus.pc_src_e & (|bus.pc_target_e[1:0]));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_id_q    <= if_id_bubble(NOP_INSTR);
      misalign_q <= 1'b0;
    end else begin
      if_id_q    <= if_id_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.pc_f         = pc_cur;
  assign bus.instr_d      = if_id_q.instr;
  assign bus.pc_d         = if_id_q.pc;
  assign bus.pc_plus_4_d  = if_id_q.pc_plus_4;
  assign bus.valid_d      = if_id_q.valid;
  assign bus.misalign_err = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_fetch.sv
// ---------------------------------------------------------------------------
// tb_pipe_fetch : directed self-checking bench for pipe_fetch
// Rev 1.0       : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_fetch;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  pipe_fetch_if bus ();

  pipe_fetch dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word tagged with its address so pc/instr pairing is visible.
  function automatic logic [31:0] imem(input logic [31:0] pc);
    return 32'h0050_0093 ^ {pc[11:0], 20'h0};
  endfunction

  assign bus.instr_f = imem(bus.pc_f);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_ctrl();
    bus.stall_f     = 1'b0;
    bus.stall_d     = 1'b0;
    bus.flush_d     = 1'b0;
    bus.pc_src_e    = 1'b0;
    bus.pc_target_e = '0;
  endtask

  task automatic test_reset();
    clear_ctrl();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.pc_f !== 32'h0) begin
      fails++; $display("FAIL reset_pc_f got %h exp %h", bus.pc_f, 32'h0);
    end
    tests++;
    if (bus.instr_d !== 32'h13 || bus.valid_d !== 1'b0 || bus.pc_d !== 32'h0 ||
        bus.pc_plus_4_d !== 32'h0 || bus.misalign_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_if_id got instr=%h v=%b pc=%h p4=%h mis=%b exp 00000013/0/0/0/0",
               bus.instr_d, bus.valid_d, bus.pc_d, bus.pc_plus_4_d, bus.misalign_err);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_free_run();
    tests++;
    if (bus.pc_f !== 32'h0 || bus.valid_d !== 1'b0) begin
      fails++; $display("FAIL run_c0 got pc_f=%h v=%b exp 0/0", bus.pc_f, bus.valid_d);
    end
    for (int i = 1; i <= 2; i++) begin
      tick();
      tests++;
      if (bus.pc_f !== 32'(4 * i) || bus.valid_d !== 1'b1 || bus.pc_d !== 32'(4 * (i - 1)) ||
          bus.pc_plus_4_d !== 32'(4 * i) || bus.instr_d !== imem(32'(4 * (i - 1)))) begin
        fails++;
        $display("FAIL run_c%0d got pc_f=%h pc_d=%h p4=%h instr=%h v=%b exp pc_f=%h pc_d=%h",
                 i, bus.pc_f, bus.pc_d, bus.pc_plus_4_d, bus.instr_d, bus.valid_d,
                 32'(4 * i), 32'(4 * (i - 1)));
      end
    end
  endtask

  task automatic test_stall();
    bus.stall_f = 1'b1;
    bus.stall_d = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (bus.pc_f !== 32'h8 || bus.pc_d !== 32'h4 || bus.instr_d !== imem(32'h4) ||
          bus.valid_d !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold%0d got pc_f=%h pc_d=%h instr=%h v=%b exp 8/4/%h/1",
                 i, bus.pc_f, bus.pc_d, bus.instr_d, bus.valid_d, imem(32'h4));
      end
    end
    clear_ctrl();
    tick();
    tests++;
    if (bus.pc_f !== 32'hC || bus.pc_d !== 32'h8 || bus.pc_plus_4_d !== 32'hC) begin
      fails++;
      $display("FAIL stall_release got pc_f=%h pc_d=%h p4=%h exp c/8/c",
               bus.pc_f, bus.pc_d, bus.pc_plus_4_d);
    end
  endtask

  task automatic test_redirect_flush();
    bus.pc_src_e    = 1'b1;
    bus.pc_target_e = 32'h100;
    bus.flush_d     = 1'b1;
    bus.stall_f     = 1'b1;
    tick();
    clear_ctrl();
    tests++;
    if (bus.pc_f !== 32'h100 || bus.instr_d !== 32'h13 || bus.valid_d !== 1'b0 ||
        bus.pc_d !== 32'h0 || bus.pc_plus_4_d !== 32'h0) begin
      fails++;
      $display("FAIL redir_flush got pc_f=%h instr=%h v=%b pc_d=%h p4=%h exp 100/13/0/0/0",
               bus.pc_f, bus.instr_d, bus.valid_d, bus.pc_d, bus.pc_plus_4_d);
    end
    tick();
    tests++;
    if (bus.pc_d !== 32'h100 || bus.instr_d !== imem(32'h100) || bus.valid_d !== 1'b1 ||
        bus.pc_f !== 32'h104) begin
      fails++;
      $display("FAIL redir_target got pc_d=%h instr=%h v=%b pc_f=%h exp 100/%h/1/104",
               bus.pc_d, bus.instr_d, bus.valid_d, bus.pc_f, imem(32'h100));
    end
  endtask

  task automatic test_misalign();
    tests++;
    if (bus.misalign_err !== 1'b0) begin
      fails++; $display("FAIL misalign_pre got %b exp 0", bus.misalign_err);
    end
    bus.pc_src_e    = 1'b1;
    bus.pc_target_e = 32'h202;
    tick();
    clear_ctrl();
    tests++;
    if (bus.pc_f !== 32'h200 || bus.misalign_err !== 1'b1) begin
      fails++;
      $display("FAIL misalign_set got pc_f=%h mis=%b exp 200/1", bus.pc_f, bus.misalign_err);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (bus.misalign_err !== 1'b1) begin
        fails++; $display("FAIL misalign_sticky%0d got %b exp 1", i, bus.misalign_err);
      end
    end
    tests++;
    if (bus.pc_f !== 32'h228) begin
      fails++; $display("FAIL misalign_run got pc_f=%h exp 228", bus.pc_f);
    end
  endtask

  task automatic test_wrap();
    bus.pc_src_e    = 1'b1;
    bus.pc_target_e = 32'hFFFF_FFFC;
    tick();
    clear_ctrl();
    tests++;
    if (bus.pc_f !== 32'hFFFF_FFFC) begin
      fails++; $display("FAIL wrap_load got pc_f=%h exp fffffffc", bus.pc_f);
    end
    tick();
    tests++;
    if (bus.pc_f !== 32'h0 || bus.pc_d !== 32'hFFFF_FFFC || bus.pc_plus_4_d !== 32'h0) begin
      fails++;
      $display("FAIL wrap_step got pc_f=%h pc_d=%h p4=%h exp 0/fffffffc/0",
               bus.pc_f, bus.pc_d, bus.pc_plus_4_d);
    end
  endtask

  task automatic test_async_reset();
    bus.pc_src_e    = 1'b1;
    bus.pc_target_e = 32'h40;
    tick();
    clear_ctrl();
    bus.stall_f = 1'b1;
    bus.stall_d = 1'b1;
    tick();
    tests++;
    if (bus.pc_f !== 32'h40) begin
      fails++; $display("FAIL areset_pre got pc_f=%h exp 40", bus.pc_f);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (bus.pc_f !== 32'h0 || bus.instr_d !== 32'h13 || bus.valid_d !== 1'b0 ||
        bus.pc_d !== 32'h0 || bus.pc_plus_4_d !== 32'h0 || bus.misalign_err !== 1'b0) begin
      fails++;
      $display("FAIL areset_now got pc_f=%h instr=%h v=%b pc_d=%h p4=%h mis=%b exp reset values",
               bus.pc_f, bus.instr_d, bus.valid_d, bus.pc_d, bus.pc_plus_4_d, bus.misalign_err);
    end
    @(negedge clk);
    clear_ctrl();
    reset_n = 1'b1;
    tests++;
    if (bus.pc_f !== 32'h0 || bus.valid_d !== 1'b0) begin
      fails++; $display("FAIL areset_rel0 got pc_f=%h v=%b exp 0/0", bus.pc_f, bus.valid_d);
    end
    tick();
    tests++;
    if (bus.pc_f !== 32'h4 || bus.pc_d !== 32'h0 || bus.valid_d !== 1'b1) begin
      fails++;
      $display("FAIL areset_rel1 got pc_f=%h pc_d=%h v=%b exp 4/0/1",
               bus.pc_f, bus.pc_d, bus.valid_d);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_flush();
    test_misalign();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
